// File: rtl/invaders_logic_pkg.sv
// Shared widths, playfield geometry, reset values and FSM encoding for invaders_logic.
package invaders_logic_pkg;

  localparam int unsigned INV_W            = 20;
  localparam int unsigned COL_W            = 5;
  localparam int unsigned ROW_W            = 4;

  localparam int unsigned SHIP_ROW         = 15;
  localparam int unsigned BULLET_START_ROW = 14;
  localparam int unsigned INV_COL_OFFSET   = 6;
  localparam int unsigned LOSE_LINE        = 14;
  localparam int unsigned COL_MAX          = 31;

  localparam logic [INV_W-1:0] INV_RST      = 20'hFFFFF;
  localparam logic [ROW_W-1:0] LINE_RST     = 4'd0;
  localparam logic [COL_W-1:0] SHIP_RST     = 5'd16;
  localparam logic [COL_W-1:0] BULLET_X_RST = 5'd0;
  localparam logic [ROW_W-1:0] BULLET_Y_RST = 4'd0;

  typedef enum logic [1:0] {
    StPlay = 2'd0,
    StWin  = 2'd1,
    StLose = 2'd2
  } state_e;

endpackage

// File: rtl/invaders_logic_if.sv
// Game-step strobe, buttons and playfield outputs of invaders_logic.
interface invaders_logic_if;
  import invaders_logic_pkg::*;

  logic             tick;
  logic             btnLeft;
  logic             btnRight;
  logic             btnFire;
  logic [INV_W-1:0] invArray;
  logic [ROW_W-1:0] invLine;
  logic [COL_W-1:0] shipX;
  logic [COL_W-1:0] bulletX;
  logic [ROW_W-1:0] bulletY;
  logic             bulletFlying;
  logic             win;
  logic             gameOver;

  modport master (
    output tick, btnLeft, btnRight, btnFire,
    input  invArray, invLine, shipX, bulletX, bulletY, bulletFlying, win, gameOver
  );

  modport slave (
    input  tick, btnLeft, btnRight, btnFire,
    output invArray, invLine, shipX, bulletX, bulletY, bulletFlying, win, gameOver
  );

endinterface

// File: rtl/invaders_logic_tick_divider.sv
// Counts enabled ticks 0..COUNT-1 and strobes expiry_o on the tick at terminal count.
module tick_divider #(
  parameter int unsigned COUNT = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic tick_i,
  output logic expiry_o
);

  localparam int unsigned CntW = (COUNT > 1) ? $clog2(COUNT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    expiry_o = tick_i && (cnt_q == CntW'(COUNT - 1));
    cnt_d    = cnt_q;
    if (tick_i) begin
      cnt_d = expiry_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/invaders_logic.sv
// Game state for a small invaders game: ship, single bullet, descending invader row, win/lose FSM.
module invaders_logic import invaders_logic_pkg::*; #(
  parameter int unsigned DESCEND_TICKS = 16,
  parameter int unsigned SHIP_TICKS    = 2
) (
  input  logic       clk,
  input  logic       clr,
  invaders_logic_if.slave bus
);

  state_e           state_q, state_d;
  logic [INV_W-1:0] inv_q, inv_d;
  logic [ROW_W-1:0] line_q, line_d;
  logic [COL_W-1:0] ship_q, ship_d;
  logic [COL_W-1:0] bx_q, bx_d;
  logic [ROW_W-1:0] by_q, by_d;
  logic             bf_q, bf_d;
  logic             pend_q, pend_d;
  logic             fire_prev_q;
  logic             win_q, game_over_q;

  logic             play_tick;
  logic             ship_exp, desc_exp;
  logic             launch, hit, in_range;
  logic [COL_W-1:0] inv_idx;

  assign play_tick = bus.tick && (state_q == StPlay);

  tick_divider #(
    .COUNT (SHIP_TICKS)
  ) u_ship_div (
    .clk      (clk),
    .clr      (clr),
    .tick_i   (play_tick),
    .expiry_o (ship_exp)
  );

  tick_divider #(
    .COUNT (DESCEND_TICKS)
  ) u_desc_div (
    .clk      (clk),
    .clr      (clr),
    .tick_i   (play_tick),
    .expiry_o (desc_exp)
  );

  assign launch   = play_tick && pend_q && !bf_q;
  assign inv_idx  = bx_q - COL_W'(INV_COL_OFFSET);
  assign in_range = (bx_q >= COL_W'(INV_COL_OFFSET)) &&
                    (bx_q <= COL_W'(INV_COL_OFFSET + INV_W - 1));
  assign hit      = (by_q == line_q) && in_range && inv_q[inv_idx];

  always_comb begin
    state_d = state_q;
    inv_d   = inv_q;
    line_d  = line_q;
    ship_d  = ship_q;
    bx_d    = bx_q;
    by_d    = by_q;
    bf_d    = bf_q;
    pend_d  = pend_q;

    // An edge arriving while already pending is absorbed by the launch clear.
    if (launch) begin
      pend_d = 1'b0;
    end else if (bus.btnFire && !fire_prev_q) begin
      pend_d = 1'b1;
    end

    if (ship_exp) begin
      if (bus.btnLeft && !bus.btnRight && (ship_q != '0)) begin
        ship_d = ship_q - 1'b1;
      end else if (bus.btnRight && !bus.btnLeft && (ship_q != COL_W'(COL_MAX))) begin
        ship_d = ship_q + 1'b1;
      end
    end

    if (launch) begin
      bf_d = 1'b1;
      bx_d = ship_q;
      by_d = ROW_W'(BULLET_START_ROW);
    end else if (play_tick && bf_q) begin
      if (hit) begin
        inv_d[inv_idx] = 1'b0;
        bf_d           = 1'b0;
      end else if (by_q == '0) begin
        bf_d = 1'b0;
      end else begin
        by_d = by_q - 1'b1;
      end
    end

    // Descent decisions look at post-hit invaders but the pre-descent row.
    if (desc_exp) begin
      if (line_q == ROW_W'(LOSE_LINE)) begin
        if (inv_d != '0) begin
          state_d = StLose;
        end
      end else begin
        line_d = line_q + 1'b1;
      end
    end

    if (play_tick && (inv_d == '0)) begin
      state_d = StWin;
    end

    if (state_d != StPlay) begin
      bf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= StPlay;
      inv_q       <= INV_RST;
      line_q      <= LINE_RST;
      ship_q      <= SHIP_RST;
      bx_q        <= BULLET_X_RST;
      by_q        <= BULLET_Y_RST;
      bf_q        <= 1'b0;
      pend_q      <= 1'b0;
      fire_prev_q <= 1'b0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inv_q       <= inv_d;
      line_q      <= line_d;
      ship_q      <= ship_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      bf_q        <= bf_d;
      pend_q      <= pend_d;
      fire_prev_q <= bus.btnFire;
      win_q       <= (state_d == StWin);
      game_over_q <= (state_d == StLose);
    end
  end

  assign bus.invArray     = inv_q;
  assign bus.invLine      = line_q;
  assign bus.shipX        = ship_q;
  assign bus.bulletX      = bx_q;
  assign bus.bulletY      = by_q;
  assign bus.bulletFlying = bf_q;
  assign bus.win          = win_q;
  assign bus.gameOver     = game_over_q;

endmodule
